instruction_cache: RTL

- Direct-mapped, read-only L1 instruction cache between the fetch stage and main memory.
- Serves 32-bit instructions to fetch from a local array of ICLLEN-bit lines.
- On a miss, stalls fetch and refills one full line over the instruction_bus consumer modport: ldp request out, ldr/ldData response in.
- Sits directly upstream of main_memory and is its only client on that bus.

---
 rtl/instruction_cache_pkg.sv | 18 +
 rtl/instruction_bus.sv | 15 +
 rtl/icache_array.sv | 49 ++++
 rtl/instruction_cache.sv | 103 ++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared constants and types for the L1 instruction cache and its refill bus.
package instruction_cache_pkg;

  localparam int unsigned ICLLEN     = 128;
  localparam int unsigned IC_ALEN    = 32;
  localparam int unsigned IC_NLINES  = 16;
  localparam int unsigned IC_WORDS   = ICLLEN / 32;
  localparam int unsigned IC_OFFBITS = $clog2(ICLLEN / 8);
  localparam int unsigned IC_IDXBITS = $clog2(IC_NLINES);
  localparam int unsigned IC_TAGBITS = IC_ALEN - IC_IDXBITS - IC_OFFBITS;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL
  } ic_state_t;

endpackage

// File: rtl/instruction_bus.sv
// Line-refill bus between the instruction cache (consumer) and main memory (producer).
interface instruction_bus
  import instruction_cache_pkg::*;
#(
  parameter int unsigned ALEN = IC_ALEN,
  parameter int unsigned LLEN = ICLLEN
);
  logic            ldp;
  logic [ALEN-1:0] ldAddr;
  logic            ldr;
  logic [LLEN-1:0] ldData;

  modport consumer (output ldp, output ldAddr, input ldr, input ldData);
  modport producer (input ldp, input ldAddr, output ldr, output ldData);
endinterface

// File: rtl/icache_array.sv
// Tag/data storage with valid bits: combinational read, synchronous write, one-cycle clear_all.
module icache_array
  import instruction_cache_pkg::*;
#(
  parameter int unsigned NLINES  = IC_NLINES,
  parameter int unsigned TAGBITS = IC_TAGBITS,
  localparam int unsigned IdxBits = $clog2(NLINES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [IdxBits-1:0] i_rd_idx,
  output logic [TAGBITS-1:0] o_rd_tag,
  output logic [ICLLEN-1:0]  o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_we,
  input  logic [IdxBits-1:0] i_wr_idx,
  input  logic [TAGBITS-1:0] i_wr_tag,
  input  logic [ICLLEN-1:0]  i_wr_data,
  input  logic               i_wr_valid,
  input  logic               i_clear_all
);

  logic [NLINES-1:0]  r_valid;
  logic [TAGBITS-1:0] r_tag  [NLINES];
  logic [ICLLEN-1:0]  r_data [NLINES];

  // clear_all has priority so a flush coinciding with a refill leaves the line invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_clear_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= i_wr_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only L1 instruction cache; zero-latency hits, single-line refill on miss.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int unsigned NLINES = IC_NLINES,
  parameter int unsigned ALEN   = IC_ALEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ALEN-1:0]         req_addr,
  input  logic                    flush,
  output logic [31:0]             instr,
  output logic                    hit,
  output logic                    stall,
  instruction_bus.consumer        bus
);

  localparam int unsigned IdxBits = $clog2(NLINES);
  localparam int unsigned TagBits = ALEN - IdxBits - IC_OFFBITS;
  localparam int unsigned SelBits = $clog2(IC_WORDS);

  ic_state_t           r_state, w_state_next;
  logic [ALEN-1:0]     r_miss_addr, w_miss_addr_next;
  logic                r_discard, w_discard_next;

  logic [IdxBits-1:0]  w_idx;
  logic [TagBits-1:0]  w_tag;
  logic [SelBits-1:0]  w_off;
  logic [TagBits-1:0]  w_rd_tag;
  logic [ICLLEN-1:0]   w_rd_line;
  logic                w_rd_valid;
  logic                w_refill;
  logic                w_unused_addr;

  assign w_idx         = req_addr[IC_OFFBITS +: IdxBits];
  assign w_tag         = req_addr[ALEN-1 -: TagBits];
  assign w_off         = req_addr[2 +: SelBits];
  assign w_unused_addr = ^req_addr[1:0];

  assign hit   = req_valid & w_rd_valid & (w_rd_tag == w_tag) & (r_state == IDLE) & ~flush;
  assign instr = hit ? w_rd_line[{w_off, 5'b0} +: 32] : 32'h0;
  assign stall = (req_valid & ~hit) | (r_state != IDLE);

  assign bus.ldp    = (r_state == FETCH);
  assign bus.ldAddr = r_miss_addr;
  assign w_refill   = (r_state == FETCH) & bus.ldr;

  icache_array #(
    .NLINES  (NLINES),
    .TAGBITS (TagBits)
  ) u_array (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_rd_idx    (w_idx),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_line),
    .o_rd_valid  (w_rd_valid),
    .i_we        (w_refill),
    .i_wr_idx    (r_miss_addr[IC_OFFBITS +: IdxBits]),
    .i_wr_tag    (r_miss_addr[ALEN-1 -: TagBits]),
    .i_wr_data   (bus.ldData),
    .i_wr_valid  (~r_discard & ~flush),
    .i_clear_all (flush)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      r_discard   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_miss_addr <= w_miss_addr_next;
      r_discard   <= w_discard_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_miss_addr_next = r_miss_addr;
    w_discard_next   = r_discard;
    unique case (r_state)
      IDLE: begin
        if (req_valid && !hit) begin
          w_state_next     = FETCH;
          w_miss_addr_next = {req_addr[ALEN-1:IC_OFFBITS], {IC_OFFBITS{1'b0}}};
        end
      end
      FETCH: begin
        if (flush) w_discard_next = 1'b1;
        if (bus.ldr) w_state_next = FILL;
      end
      FILL: begin
        // ldp is low here, so memory is idle again before the next lookup can miss.
        w_state_next   = IDLE;
        w_discard_next = 1'b0;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
